map_writer: RTL and testbench

- Write-side counterpart of the occupancy-map builder.
- When the active piece lands, stamps the 4x4 piece into the 8x8 Red/Green/Blue colour maps.
- Then scans and removes full rows, shifting the rows above down by one.
- Its colour-map outputs drive the map builder and the LED matrix; the game FSM issues lock_req and waits for done before loading the next block.

---
 rtl/map_writer.sv | 181 ++++++++++++++++++
 tb/tb_map_writer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/map_writer.sv
// map_writer: commits a landed 4x4 piece into the 8x8 R/G/B colour maps,
// then scans bottom-up and removes full rows, shifting the rows above down.
// Optional feature: define SCORE_EN to add a saturating 16-bit score output.
module map_writer #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int X_OFS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lock_req,
    input  logic [15:0]          block,
    input  logic [3:0]           cur_x,
    input  logic [3:0]           cur_y,
    input  logic [2:0]           color,
    output logic [ROWS*COLS-1:0] Red_map,
    output logic [ROWS*COLS-1:0] Green_map,
    output logic [ROWS*COLS-1:0] Blue_map,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines_cleared
`ifdef SCORE_EN
    ,
    output logic [15:0]          score
`endif
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);

    typedef enum logic [2:0] {S_IDLE, S_STAMP, S_SCAN, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [2:0]      lines_q, lines_d;
    logic [N-1:0]    red_q, green_q, blue_q;
    logic [N-1:0]    red_d, green_d, blue_d;
    logic [15:0]     blk_q;
    logic [3:0]      x_q, y_q;
    logic [2:0]      col_q;
    logic            accept;
    logic            row_full;
    logic [N-1:0]    occ;
    logic [4:0]      tr, tc;
    int              idx;

    // Occupancy of the row currently under scan (row 0 sits in the top byte).
    always_comb begin
        occ      = red_q | green_q | blue_q;
        row_full = &occ[(ROWS-1-int'(row_q))*COLS +: COLS];
    end

    // Next-state, next-map and bookkeeping for the commit FSM.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        lines_d = lines_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        accept  = 1'b0;
        tr      = '0;
        tc      = '0;
        idx     = 0;
        case (state_q)
            S_IDLE: begin
                if (lock_req) begin
                    accept  = 1'b1;
                    lines_d = '0;
                    state_d = S_STAMP;
                end
            end
            S_STAMP: begin
                // 5-bit target coordinates: anything off the board (including
                // columns left of the wall, which wrap to large values) is dropped.
                for (int pr = 0; pr < 4; pr++) begin
                    for (int pc = 0; pc < 4; pc++) begin
                        tr = 5'(y_q) + 5'(pr);
                        tc = 5'(x_q) + 5'(pc) - 5'(X_OFS);
                        if (blk_q[15-(pr*4+pc)] && int'(tr) < ROWS && int'(tc) < COLS) begin
                            idx          = N - 1 - (int'(tr) * COLS + int'(tc));
                            red_d[idx]   = col_q[2];
                            green_d[idx] = col_q[1];
                            blue_d[idx]  = col_q[0];
                        end
                    end
                end
                row_d   = RW'(ROWS-1);
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (row_full)            state_d = S_SHIFT;
                else if (row_q == '0)    state_d = S_DONE;
                else                     row_d   = row_q - RW'(1);
            end
            S_SHIFT: begin
                // Rows 0..row-1 drop by one; the vacated top row is cleared.
                for (int r = 0; r < ROWS; r++) begin
                    if (r <= int'(row_q)) begin
                        if (r == 0) begin
                            red_d[(ROWS-1)*COLS +: COLS]   = '0;
                            green_d[(ROWS-1)*COLS +: COLS] = '0;
                            blue_d[(ROWS-1)*COLS +: COLS]  = '0;
                        end else begin
                            red_d[(ROWS-1-r)*COLS +: COLS]   = red_q[(ROWS-r)*COLS +: COLS];
                            green_d[(ROWS-1-r)*COLS +: COLS] = green_q[(ROWS-r)*COLS +: COLS];
                            blue_d[(ROWS-1-r)*COLS +: COLS]  = blue_q[(ROWS-r)*COLS +: COLS];
                        end
                    end
                end
                if (lines_q != 3'd7) lines_d = lines_q + 3'd1;
                state_d = S_SCAN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, maps and the piece snapshot taken at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            lines_q <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            blk_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            lines_q <= lines_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            if (accept) begin
                blk_q <= block;
                x_q   <= cur_x;
                y_q   <= cur_y;
                col_q <= color;
            end
        end
    end

    assign Red_map       = red_q;
    assign Green_map     = green_q;
    assign Blue_map      = blue_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign lines_cleared = lines_q;

`ifdef SCORE_EN
    logic [15:0] score_q;
    logic [3:0]  pts;

    // Points awarded for the number of rows removed by this commit.
    always_comb begin
        case (lines_q)
            3'd0:    pts = 4'd0;
            3'd1:    pts = 4'd1;
            3'd2:    pts = 4'd3;
            3'd3:    pts = 4'd5;
            default: pts = 4'd8;
        endcase
    end

    // Saturating score accumulation on the done cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            score_q <= '0;
        else if (state_q == S_DONE)
            score_q <= (17'(score_q) + 17'(pts) > 17'h0FFFF) ? 16'hFFFF : score_q + 16'(pts);
    end

    assign score = score_q;
`endif

endmodule

// File: tb/tb_map_writer.sv
// Directed bench for map_writer: stamping, row clears with shift, clipping,
// ignored requests while busy and asynchronous reset mid-commit.
// Latency is counted in edges with the acceptance edge as edge 1.
module tb_map_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        lock_req;
    logic [15:0] block;
    logic [3:0]  cur_x, cur_y;
    logic [2:0]  color;
    logic [63:0] Red_map, Green_map, Blue_map;
    logic        busy, done;
    logic [2:0]  lines_cleared;
`ifdef SCORE_EN
    logic [15:0] score;
`endif

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int edges;
    int d0;

    map_writer dut (
        .clk           (clk),
        .reset         (reset),
        .lock_req      (lock_req),
        .block         (block),
        .cur_x         (cur_x),
        .cur_y         (cur_y),
        .color         (color),
        .Red_map       (Red_map),
        .Green_map     (Green_map),
        .Blue_map      (Blue_map),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
`ifdef SCORE_EN
        ,
        .score         (score)
`endif
    );

    always #5 clk = ~clk;

    // done is high for whole cycles, so each pulse is seen on one falling edge
    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one commit and wait for done; optionally fire a stray lock_req
    // (with different piece data) while the commit is in progress.
    task automatic commit(input logic [15:0] b, input logic [3:0] x, input logic [3:0] y,
                          input logic [2:0] c, input bit inj, output int n);
        @(negedge clk);
        block = b; cur_x = x; cur_y = y; color = c; lock_req = 1'b1;
        @(posedge clk);
        n = 1;
        #1 lock_req = 1'b0;
        while (!done && n < 64) begin
            lock_req = inj && (n == 3);
            if (inj && n == 3) begin
                block = 16'h8000; cur_x = 4'd3; cur_y = 4'd0; color = 3'b100;
            end
            @(posedge clk);
            n++;
            #1;
        end
        lock_req = 1'b0;
        chk("done_seen", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; lock_req = 1'b0; block = '0; cur_x = '0; cur_y = '0; color = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_red",   Red_map,   64'd0);
        chk("rst_green", Green_map, 64'd0);
        chk("rst_blue",  Blue_map,  64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_lines", {61'd0, lines_cleared}, 64'd0);
        @(negedge clk) reset = 1'b0;

        // simple stamp: row 7 cols 0-3 red
        commit(16'hF000, 4'd3, 4'd7, 3'b100, 1'b0, edges);
        chk("stamp_lat",   edges, 10);
        chk("stamp_red",   Red_map,   64'h0000_0000_0000_00F0);
        chk("stamp_green", Green_map, 64'd0);
        chk("stamp_blue",  Blue_map,  64'd0);
        chk("stamp_lines", {61'd0, lines_cleared}, 64'd0);
        chk("stamp_busy",  {63'd0, busy}, 64'd0);

        // single clear: cols 4-7 green completes row 7
        commit(16'hF000, 4'd7, 4'd7, 3'b010, 1'b0, edges);
        chk("clr1_lat",   edges, 12);
        chk("clr1_red",   Red_map,   64'd0);
        chk("clr1_green", Green_map, 64'd0);
        chk("clr1_blue",  Blue_map,  64'd0);
        chk("clr1_lines", {61'd0, lines_cleared}, 64'd1);

        // double clear: rows 6-7 red cols 0-6, row 5 col 0 blue, then bar at col 7
        commit(16'hFF00, 4'd3, 4'd6, 3'b100, 1'b0, edges);
        commit(16'hEE00, 4'd7, 4'd6, 3'b100, 1'b0, edges);
        commit(16'h8000, 4'd3, 4'd5, 3'b001, 1'b0, edges);
        chk("pre2_red",  Red_map,  64'h0000_0000_0000_FEFE);
        chk("pre2_blue", Blue_map, 64'h0000_0000_0080_0000);
        commit(16'h8888, 4'd10, 4'd4, 3'b001, 1'b0, edges);
        chk("clr2_lat",   edges, 14);
        chk("clr2_red",   Red_map,   64'd0);
        chk("clr2_green", Green_map, 64'd0);
        chk("clr2_blue",  Blue_map,  64'h0000_0000_0000_0181);
        chk("clr2_lines", {61'd0, lines_cleared}, 64'd2);

        // clipping plus a stray request while busy
        d0 = done_cnt;
        commit(16'hFFFF, 4'd9, 4'd6, 3'b010, 1'b1, edges);
        repeat (20) @(posedge clk);
        #1;
        chk("clip_lat",   edges, 10);
        chk("clip_red",   Red_map,   64'd0);
        chk("clip_green", Green_map, 64'h0000_0000_0000_0303);
        chk("clip_blue",  Blue_map,  64'h0000_0000_0000_0080);
        chk("clip_lines", {61'd0, lines_cleared}, 64'd0);
        chk("clip_ndone", done_cnt - d0, 1);
        chk("clip_busy",  {63'd0, busy}, 64'd0);

        // reset during SHIFT: cols 1-4 red, then col 5 completes row 7
        commit(16'hF000, 4'd4, 4'd7, 3'b100, 1'b0, edges);
        chk("pre3_red", Red_map, 64'h0000_0000_0000_0078);
        @(negedge clk);
        block = 16'h8000; cur_x = 4'd8; cur_y = 4'd7; color = 3'b001; lock_req = 1'b1;
        @(posedge clk);                  // acceptance
        #1 lock_req = 1'b0;
        @(posedge clk);                  // stamp
        @(posedge clk);                  // scan row 7 -> shift
        #1;
        chk("mid_row7", {56'd0, Red_map[7:0] | Green_map[7:0] | Blue_map[7:0]}, 64'hFF);
        chk("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("arst_red",   Red_map,   64'd0);
        chk("arst_green", Green_map, 64'd0);
        chk("arst_blue",  Blue_map,  64'd0);
        chk("arst_busy",  {63'd0, busy}, 64'd0);
`ifdef SCORE_EN
        chk("arst_score", {48'd0, score}, 64'd0);
`endif
        @(negedge clk) reset = 1'b0;

        // fresh single clear after the reset
        commit(16'hF000, 4'd3, 4'd7, 3'b100, 1'b0, edges);
        commit(16'hF000, 4'd7, 4'd7, 3'b010, 1'b0, edges);
        chk("post_lat",   edges, 12);
        chk("post_lines", {61'd0, lines_cleared}, 64'd1);
        chk("post_red",   Red_map, 64'd0);
`ifdef SCORE_EN
        chk("post_score", {48'd0, score}, 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
